// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU control encodings, forward selects and
// the hard-wired zero register index.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucont_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forward select plus 3:1 data mux. The M stage holds the younger
// result, so it wins over W. Register zero is never forwarded.
import mips_pkg::*;

module fwd_mux #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic [REGW-1:0]  src,
  input  logic [WIDTH-1:0] regval,
  input  logic             regwrite_m,
  input  logic [REGW-1:0]  writereg_m,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic             regwrite_w,
  input  logic [REGW-1:0]  writereg_w,
  input  logic [WIDTH-1:0] result_w,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] value
);

  // Pick the youngest in-flight producer of src, then route its data.
  always_comb begin
    sel = FWD_REG;
    if (src != REGW'(REG_ZERO)) begin
      if (regwrite_m && (writereg_m == src))
        sel = FWD_M;
      else if (regwrite_w && (writereg_w == src))
        sel = FWD_W;
    end
    case (sel)
      FWD_M:   value = aluout_m;
      FWD_W:   value = result_w;
      default: value = regval;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding and load-use
// hazard detection. Optional feature macro: ID_EX_FORWARD_EN (when undefined,
// no forwarding is done and hazard_stall also covers every RAW dependency on
// the E and M stages).
import mips_pkg::*;

module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  rd_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic [2:0]       alucont_d,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [REGW-1:0]  writereg_m,
  input  logic             regwrite_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [REGW-1:0]  writereg_w,
  input  logic             regwrite_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       alucont_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [REGW-1:0]  writereg_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             valid_e,
  output logic [1:0]       fwda_e,
  output logic [1:0]       fwdb_e,
  output logic             hazard_stall
);

  logic [WIDTH-1:0] rd1_e, rd2_e, signimm_e;
  logic [REGW-1:0]  rs_e, rt_e, rd_e;
  logic             alusrc_e, regdst_e;
  logic [WIDTH-1:0] fwd_rt;
  logic             fwd_en_m, fwd_en_w;
  logic             load_use;

  // E-stage register: reset/flush insert a bubble, stall holds, else load D.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      alucont_e  <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      signimm_e  <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
    end else if (!stall_e) begin
      valid_e    <= valid_d;
      regwrite_e <= valid_d & regwrite_d;
      memtoreg_e <= valid_d & memtoreg_d;
      memwrite_e <= valid_d & memwrite_d;
      alusrc_e   <= valid_d & alusrc_d;
      regdst_e   <= valid_d & regdst_d;
      alucont_e  <= valid_d ? alucont_d : '0;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      signimm_e  <= signimm_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  assign fwd_en_m = regwrite_m;
  assign fwd_en_w = regwrite_w;
`else
  // Muxes stay in place with their enables held low so selects read 00.
  assign fwd_en_m = 1'b0;
  assign fwd_en_w = 1'b0;
  logic unused_regwrite_w;
  assign unused_regwrite_w = regwrite_w;
`endif

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_a (
    .src(rs_e), .regval(rd1_e),
    .regwrite_m(fwd_en_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
    .regwrite_w(fwd_en_w), .writereg_w(writereg_w), .result_w(result_w),
    .sel(fwda_e), .value(srca_e)
  );

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_b (
    .src(rt_e), .regval(rd2_e),
    .regwrite_m(fwd_en_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
    .regwrite_w(fwd_en_w), .writereg_w(writereg_w), .result_w(result_w),
    .sel(fwdb_e), .value(fwd_rt)
  );

  // Operand B source, store data and destination index selection.
  always_comb begin
    writedata_e = fwd_rt;
    srcb_e      = alusrc_e ? signimm_e : fwd_rt;
    writereg_e  = regdst_e ? rd_e : rt_e;
  end

  // Stall request: load-use always; any E/M RAW when forwarding is absent.
  always_comb begin
    load_use = valid_e & memtoreg_e & (rt_e != '0) &
               ((rt_e == rs_d) | (rt_e == rt_d));
`ifdef ID_EX_FORWARD_EN
    hazard_stall = load_use;
`else
    hazard_stall = load_use
      | (valid_e & regwrite_e & (writereg_e != '0) &
         ((writereg_e == rs_d) | (writereg_e == rt_d)))
      | (regwrite_m & (writereg_m != '0) &
         ((writereg_m == rs_d) | (writereg_m == rt_d)));
`endif
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, then randomized traffic
// against a behavioural model of the E-stage contents.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        reset, stall, flush, valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]  alucont;
    logic [31:0] aluout_m;
    logic [4:0]  writereg_m;
    logic        regwrite_m;
    logic [31:0] result_w;
    logic [4:0]  writereg_w;
    logic        regwrite_w;
  } vin_t;

  typedef struct packed {
    logic [31:0] srca, srcb, writedata;
    logic [4:0]  writereg;
    logic [2:0]  alucont;
    logic        regwrite, memtoreg, memwrite, valid;
    logic [1:0]  fwda, fwdb;
    logic        hazard;
  } exp_t;

  typedef struct packed {
    vin_t i;
    exp_t e;
  } row_t;

  // Contents of the E stage as the bench understands the instruction in it.
  typedef struct packed {
    logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]  alucont;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  vin_t vi;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucont_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, valid_e, hazard_stall;
  logic [1:0]  fwda_e, fwdb_e;

  id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(vi.reset), .stall_e(vi.stall), .flush_e(vi.flush),
    .valid_d(vi.valid), .rd1_d(vi.rd1), .rd2_d(vi.rd2), .signimm_d(vi.imm),
    .rs_d(vi.rs), .rt_d(vi.rt), .rd_d(vi.rd),
    .regwrite_d(vi.regwrite), .memtoreg_d(vi.memtoreg), .memwrite_d(vi.memwrite),
    .alusrc_d(vi.alusrc), .regdst_d(vi.regdst), .alucont_d(vi.alucont),
    .aluout_m(vi.aluout_m), .writereg_m(vi.writereg_m), .regwrite_m(vi.regwrite_m),
    .result_w(vi.result_w), .writereg_w(vi.writereg_w), .regwrite_w(vi.regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucont_e(alucont_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .valid_e(valid_e), .fwda_e(fwda_e), .fwdb_e(fwdb_e),
    .hazard_stall(hazard_stall)
  );

  int unsigned npass = 0;
  int unsigned nchk  = 0;
  row_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".srca"},      srca_e,              e.srca);
    check({tag, ".srcb"},      srcb_e,              e.srcb);
    check({tag, ".writedata"}, writedata_e,         e.writedata);
    check({tag, ".writereg"},  32'(writereg_e),     32'(e.writereg));
    check({tag, ".alucont"},   32'(alucont_e),      32'(e.alucont));
    check({tag, ".regwrite"},  32'(regwrite_e),     32'(e.regwrite));
    check({tag, ".memtoreg"},  32'(memtoreg_e),     32'(e.memtoreg));
    check({tag, ".memwrite"},  32'(memwrite_e),     32'(e.memwrite));
    check({tag, ".valid"},     32'(valid_e),        32'(e.valid));
    check({tag, ".fwda"},      32'(fwda_e),         32'(e.fwda));
    check({tag, ".fwdb"},      32'(fwdb_e),         32'(e.fwdb));
    check({tag, ".hazard"},    32'(hazard_stall),   32'(e.hazard));
  endtask

  // Which stage supplies register r: 2 = M, 1 = W, 0 = register file.
  function automatic int source_of(input logic [4:0] r, input vin_t v);
    if (!FWD || r == 0) return 0;
    if (v.regwrite_m && v.writereg_m == r) return 2;
    if (v.regwrite_w && v.writereg_w == r) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] value_of(input int s, input logic [31:0] rf, input vin_t v);
    return (s == 2) ? v.aluout_m : (s == 1) ? v.result_w : rf;
  endfunction

  function automatic exp_t model_out(input instr_t m, input vin_t v);
    exp_t e;
    int   sa, sb;
    logic [4:0] dst;
    bit   reads_d;
    sa = source_of(m.rs, v);
    sb = source_of(m.rt, v);
    dst = m.regdst ? m.rd : m.rt;
    e.srca      = value_of(sa, m.rd1, v);
    e.writedata = value_of(sb, m.rd2, v);
    e.srcb      = m.alusrc ? m.imm : e.writedata;
    e.writereg  = dst;
    e.alucont   = m.alucont;
    e.regwrite  = m.regwrite;
    e.memtoreg  = m.memtoreg;
    e.memwrite  = m.memwrite;
    e.valid     = m.valid;
    e.fwda      = 2'(sa);
    e.fwdb      = 2'(sb);
    reads_d     = (m.rt != 0) && (m.rt == v.rs || m.rt == v.rt);
    e.hazard    = m.valid && m.memtoreg && reads_d;
    if (!FWD) begin
      if (m.valid && m.regwrite && dst != 0 && (dst == v.rs || dst == v.rt)) e.hazard = 1'b1;
      if (v.regwrite_m && v.writereg_m != 0 &&
          (v.writereg_m == v.rs || v.writereg_m == v.rt)) e.hazard = 1'b1;
    end
    return e;
  endfunction

  function automatic instr_t model_next(input instr_t m, input vin_t v);
    instr_t n;
    if (v.reset || v.flush) return '0;
    if (v.stall) return m;
    n = '0;
    n.rd1 = v.rd1; n.rd2 = v.rd2; n.imm = v.imm;
    n.rs = v.rs; n.rt = v.rt; n.rd = v.rd;
    if (v.valid) begin
      n.valid = 1'b1;
      n.regwrite = v.regwrite; n.memtoreg = v.memtoreg; n.memwrite = v.memwrite;
      n.alusrc = v.alusrc; n.regdst = v.regdst; n.alucont = v.alucont;
    end
    return n;
  endfunction

  task automatic add(input vin_t v, input exp_t e);
    row_t r;
    r.i = v; r.e = e;
    tbl.push_back(r);
  endtask

  initial begin
    vin_t   v;
    exp_t   e;
    instr_t m;

    // R0/R1: reset held with busy D inputs
    v = '0; e = '0;
    v.reset = 1; v.valid = 1; v.rd1 = 32'h11; v.rd2 = 32'h22; v.imm = 32'h33;
    v.rs = 1; v.rt = 2; v.rd = 3; v.regwrite = 1; v.memtoreg = 1; v.memwrite = 1;
    v.alusrc = 1; v.regdst = 1; v.alucont = 3'b010;
    add(v, e); add(v, e);
    // R2: first load, rd1=5 rd2=7 add, rs=3 rt=4
    v = '0; v.valid = 1; v.rd1 = 5; v.rd2 = 7; v.alucont = 3'b010;
    v.rs = 3; v.rt = 4; v.rd = 9; v.regwrite = 1;
    add(v, e);
    // R3: stalled, M and W both write r3 -> M wins
    v = '0; v.stall = 1; v.rd1 = 32'hA; v.rd2 = 32'hB;
    v.aluout_m = 32'h10; v.writereg_m = 3; v.regwrite_m = 1;
    v.result_w = 32'h20; v.writereg_w = 3; v.regwrite_w = 1;
    e = '0; e.srca = FWD ? 32'h10 : 32'h5; e.fwda = FWD ? 2'b10 : 2'b00;
    e.srcb = 7; e.writedata = 7; e.writereg = 4; e.regwrite = 1; e.valid = 1; e.alucont = 3'b010;
    add(v, e);
    // R4: M drops out -> W value
    v.regwrite_m = 0;
    e.srca = FWD ? 32'h20 : 32'h5; e.fwda = FWD ? 2'b01 : 2'b00;
    add(v, e);
    // R5: load rs=0 instruction, M targets r0
    v = '0; v.valid = 1; v.rd1 = 32'h33; v.rd2 = 32'h44; v.alucont = 3'b110;
    v.writereg_m = 0; v.regwrite_m = 1; v.aluout_m = 32'hBAD;
    e.srca = 5; e.fwda = 0;
    add(v, e);
    // R6: r0 never forwarded; present lw rt=8
    v = '0; v.writereg_m = 0; v.regwrite_m = 1; v.aluout_m = 32'hBAD;
    v.writereg_w = 0; v.regwrite_w = 1; v.result_w = 32'h99;
    v.valid = 1; v.regwrite = 1; v.memtoreg = 1; v.rs = 1; v.rt = 8;
    v.rd1 = 32'h100; v.rd2 = 32'h200; v.alucont = 3'b010; v.alusrc = 1; v.imm = 4;
    e = '0; e.srca = 32'h33; e.srcb = 32'h44; e.writedata = 32'h44; e.alucont = 3'b110; e.valid = 1;
    add(v, e);
    // R7: lw in E, dependent add (rs=8) in D -> load-use; flush E
    v = '0; v.valid = 1; v.regwrite = 1; v.regdst = 1; v.rs = 8; v.rt = 2; v.rd = 10;
    v.rd1 = 32'h55; v.rd2 = 32'h66; v.alucont = 3'b010; v.flush = 1;
    e = '0; e.srca = 32'h100; e.srcb = 4; e.writedata = 32'h200; e.writereg = 8;
    e.regwrite = 1; e.memtoreg = 1; e.valid = 1; e.alucont = 3'b010; e.hazard = 1;
    add(v, e);
    // R8: bubble in E, lw now in M
    v.flush = 0; v.aluout_m = 32'h104; v.writereg_m = 8; v.regwrite_m = 1;
    e = '0; e.hazard = !FWD;
    add(v, e);
    // R9: add in E takes the load result from W; present immediate op
    v = '0; v.valid = 1; v.alusrc = 1; v.imm = 32'hFFFF_FFFC; v.regdst = 1; v.rd = 9;
    v.rt = 4; v.rs = 5; v.rd1 = 32'h77; v.rd2 = 32'h88; v.regwrite = 1; v.alucont = 3'b010;
    v.writereg_w = 8; v.regwrite_w = 1; v.result_w = 32'hDEAD;
    e = '0; e.srca = FWD ? 32'hDEAD : 32'h55; e.fwda = FWD ? 2'b01 : 2'b00;
    e.srcb = 32'h66; e.writedata = 32'h66; e.writereg = 10; e.regwrite = 1; e.valid = 1;
    e.alucont = 3'b010;
    add(v, e);
    // R10..R12: three stalled cycles with changing D
    v = '0; v.stall = 1; v.valid = 1; v.rs = 6; v.rt = 7; v.rd = 1; v.rd1 = 1; v.rd2 = 2;
    v.alucont = 3'b001; v.writereg_m = 4; v.regwrite_m = 1; v.aluout_m = 32'hAB;
    e = '0; e.srca = 32'h77; e.srcb = 32'hFFFF_FFFC; e.writedata = FWD ? 32'hAB : 32'h88;
    e.fwdb = FWD ? 2'b10 : 2'b00; e.writereg = 9; e.regwrite = 1; e.valid = 1; e.alucont = 3'b010;
    add(v, e);
    v = '0; v.stall = 1; v.valid = 1; v.rs = 2; v.rt = 3; v.rd1 = 3; v.rd2 = 4;
    v.alucont = 3'b011; v.regwrite = 1;
    e.writedata = 32'h88; e.fwdb = 2'b00;
    add(v, e);
    v.rs = 1; v.rt = 1; v.rd1 = 9;
    add(v, e);
    // R13: flush while stalled still loads a bubble
    v.flush = 1;
    add(v, e);
    // R14/R15: bubble visible
    v = '0; e = '0;
    add(v, e); add(v, e);

    vi = '0; vi.reset = 1;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      vi = tbl[k].i;
      #4;
      check_all($sformatf("vec%0d", k), tbl[k].e);
      @(posedge clk); #1;
    end

    m = '0;
    for (int c = 0; c < 600; c++) begin
      v = '0;
      v.reset    = (c == 0) || ($urandom_range(0, 60) == 0);
      v.stall    = ($urandom_range(0, 5) == 0);
      v.flush    = ($urandom_range(0, 9) == 0);
      v.valid    = ($urandom_range(0, 4) != 0);
      v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom;
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.rd = 5'($urandom_range(0, 3));
      v.regwrite = 1'($urandom); v.memtoreg = 1'($urandom); v.memwrite = 1'($urandom);
      v.alusrc = 1'($urandom); v.regdst = 1'($urandom); v.alucont = 3'($urandom);
      v.aluout_m = $urandom; v.writereg_m = 5'($urandom_range(0, 3)); v.regwrite_m = 1'($urandom);
      v.result_w = $urandom; v.writereg_w = 5'($urandom_range(0, 3)); v.regwrite_w = 1'($urandom);
      vi = v;
      #4;
      if (c > 0) check_all($sformatf("rnd%0d", c), model_out(m, v));
      @(posedge clk);
      m = model_next(m, v);
      #1;
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
